// File: rtl/spike_stream_driver.sv
// Host-side rate encoder and readout for the spiking network's sample handshake.
// Presents N_STEPS spike vectors per inference, counts output spikes, reports argmax.
module spike_stream_driver #(
  parameter int unsigned N_IN         = 4,
  parameter int unsigned N_OUT        = 2,
  parameter int unsigned N_STEPS      = 3,
  parameter int unsigned INT_W        = 8,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned DRAIN_CYCLES = 32
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          pix_valid,
  output logic                                          pix_ready,
  input  logic [N_IN*INT_W-1:0]                         pix_data,
  input  logic                                          net_ready,
  output logic                                          net_start,
  input  logic                                          net_sample,
  output logic                                          net_sample_ready,
  output logic [N_IN-1:0]                               net_in_spikes,
  input  logic [N_OUT-1:0]                              net_out_spikes,
  output logic                                          res_valid,
  output logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0]  res_class,
  output logic [N_OUT*CNT_W-1:0]                        res_counts
);

  localparam int unsigned CLS_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned STEP_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int unsigned DRN_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, WAIT_RDY, RUN, DRAIN, REPORT} state_t;

  state_t                  state;
  logic [N_IN*INT_W-1:0]   pix;
  logic [INT_W-1:0]        acc [N_IN];
  logic [CNT_W-1:0]        cnt [N_OUT];
  logic [N_OUT-1:0]        prev;
  logic [STEP_W-1:0]       step_cnt;
  logic [DRN_W-1:0]        drain_cnt;
  logic                    loading;

  logic [INT_W:0]          sum_c [N_IN];
  logic [N_IN-1:0]         spk_c;
  logic [CNT_W-1:0]        best_c;
  logic [CLS_W-1:0]        cls_c;

  // Rate encoder: carry out of the per-input phase accumulator is the spike
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      sum_c[i] = {1'b0, acc[i]} + {1'b0, pix[i*INT_W +: INT_W]};
      spk_c[i] = sum_c[i][INT_W];
    end
  end

  // Argmax with ties resolved to the lowest index
  always_comb begin
    best_c = cnt[0];
    cls_c  = '0;
    for (int k = 1; k < N_OUT; k++) begin
      if (cnt[k] > best_c) begin
        best_c = cnt[k];
        cls_c  = CLS_W'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      pix_ready        <= 1'b1;
      net_start        <= 1'b0;
      net_sample_ready <= 1'b0;
      net_in_spikes    <= '0;
      res_valid        <= 1'b0;
      res_class        <= '0;
      res_counts       <= '0;
      pix              <= '0;
      prev             <= '0;
      step_cnt         <= '0;
      drain_cnt        <= '0;
      loading          <= 1'b0;
      for (int i = 0; i < N_IN; i++) acc[i] <= '0;
      for (int k = 0; k < N_OUT; k++) cnt[k] <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pix_valid && pix_ready) begin
            pix           <= pix_data;
            pix_ready     <= 1'b0;
            step_cnt      <= '0;
            loading       <= 1'b0;
            prev          <= '0;
            net_in_spikes <= '0;
            // Step 0 runs from a zero accumulator, so its vector is empty
            for (int i = 0; i < N_IN; i++) acc[i] <= pix_data[i*INT_W +: INT_W];
            for (int k = 0; k < N_OUT; k++) cnt[k] <= '0;
            state         <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (net_ready) begin
            net_start        <= 1'b1;
            net_sample_ready <= 1'b1;
            state            <= RUN;
          end
        end
        RUN: begin
          if (loading) begin
            net_in_spikes    <= spk_c;
            net_sample_ready <= 1'b1;
            loading          <= 1'b0;
            for (int i = 0; i < N_IN; i++) acc[i] <= sum_c[i][INT_W-1:0];
          end else if (net_sample && net_sample_ready) begin
            net_start        <= 1'b0;
            net_sample_ready <= 1'b0;
            if (step_cnt == STEP_W'(N_STEPS - 1)) begin
              drain_cnt <= '0;
              state     <= DRAIN;
            end else begin
              step_cnt <= step_cnt + 1'b1;
              loading  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRN_W'(DRAIN_CYCLES - 1)) state <= REPORT;
          else drain_cnt <= drain_cnt + 1'b1;
        end
        REPORT: begin
          res_valid <= 1'b1;
          res_class <= cls_c;
          for (int k = 0; k < N_OUT; k++) res_counts[k*CNT_W +: CNT_W] <= cnt[k];
          pix_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Rising-edge spike counters, live only while the network is being driven
      if (state == RUN || state == DRAIN) begin
        prev <= net_out_spikes;
        for (int k = 0; k < N_OUT; k++) begin
          if (net_out_spikes[k] && !prev[k] && cnt[k] != CNT_MAX) cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

endmodule
